aes_icipher_ctrl: RTL and testbench
===================================

# aes_icipher_ctrl

Sequencer and two-port arbiter for the iterative inverse-cipher engine `aes_icipher_state`. It accepts 16-byte ciphertext blocks from two independent requesters over valid/ready handshakes. It launches one block at a time into the engine and waits for the engine's done pulse. It holds the plaintext in a response buffer until the owning requester takes it. The block sits between the system-side request ports and one `aes_icipher_state` instance. Key schedule (KExp) and the IBox/EXP3/LN3 tables are wired to the engine directly and are not touched here.

## Interface
- `NREQ`, 2: number of requesters. Fixed at 2; other values are unsupported.
- `TMO`, Nr+4: watchdog limit in cycles while waiting for the engine.
- `rst`  in  1  asynchronous, active-low reset.
- `clk`  in  1  single clock; everything is on posedge.
- `req_valid`  in  [NREQ]  requester i presents a block.
- `req_data`  in  [NREQ][0:4*Nb-1] x 8  ciphertext bytes, in the engine's byte order.
- `req_ready`  out  [NREQ]  block accepted this cycle when valid&ready.
- `rsp_valid`  out  [NREQ]  plaintext available for requester i.
- `rsp_ready`  in  [NREQ]  requester i consumes the response.
- `rsp_data`  out  [0:4*Nb-1] x 8  plaintext, shared by both requesters; qualified by `rsp_valid`.
- `eng_data`  out  [0:4*Nb-1] x 8  block to the engine's Data_in.
- `eng_enable`  out  1  launch pulse to the engine's Enable.
- `eng_data_out`  in  [0:4*Nb-1] x 8  engine's Data_out.
- `eng_ready`  in  1  engine's Ready_out, a one-cycle done pulse.
- `err_timeout`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- FSM states and transitions:
  - IDLE: grant computed combinationally. `req_ready[g]`=1 only for the granted requester that has `req_valid`. On handshake, latch `req_data` into `in_buf` and the owner into `owner`, then go to LAUNCH.
  - LAUNCH: `eng_enable`=1 for exactly this cycle; `eng_data`=`in_buf`. Clear `wdog`, then go to BUSY.
  - BUSY: `wdog` increments each cycle.
    - If `eng_ready`=1: latch `eng_data_out` into `out_buf` and go to HOLD.
    - Else if `wdog`==TMO-1: pulse `err_timeout`, discard the transaction, go to IDLE.
  - HOLD: `rsp_valid[owner]`=1, `rsp_data`=`out_buf`. On `rsp_ready[owner]`, go to IDLE.
- Arbitration without the macro is fixed priority: requester 0 wins whenever both are valid.
- The engine cannot stall. Launch therefore happens only when `out_buf` is free, which the FSM guarantees because HOLD must drain first.
- `eng_data` is `in_buf` in all states; the engine samples it only in the launch cycle.
- `eng_ready` outside BUSY is ignored and does not change state.
- `rsp_ready` outside HOLD, or from the non-owner, is ignored.
- `wdog` is $clog2(TMO+1) bits wide and saturates; it never wraps.
- Reset mid-operation: all state returns to IDLE and any in-flight block is lost. The engine is reset by the same `rst`, so its round counter returns to Nr.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `eng_enable`=0, `err_timeout`=0.
  - `rsp_data`=0, `eng_data`=0.
  - FSM=IDLE, `wdog`=0.
  - Round-robin pointer = requester 0.
- Accept at cycle A gives `eng_enable` at A+1 and `eng_ready` at A+Nr+2.
- `rsp_valid` rises at A+Nr+3. For AES-128 (Nr=10) that is A+13.
- A response handshake at cycle H puts the FSM in IDLE at H+1; the earliest next accept is H+1.
- Throughput with immediate `rsp_ready`: one block per Nr+4 cycles.

## Configuration
- `AES_ICIPHER_RR_EN` defined: round-robin arbitration.
  - The pointer advances past the winner on each accept.
  - With both requesters continuously valid, grants alternate 0,1,0,1.
- Undefined: fixed priority to requester 0, and the pointer logic is omitted.

## Structure
- In the shared package `aes_wire`: FSM state enum `ctrl_state_t` (IDLE, LAUNCH, BUSY, HOLD) and a packed `ctrl_reg_type` holding state, `owner`, `wdog` and `rr_ptr`.
- Nb and Nr come from `aes_const`.
- One sub-module, `aes_rr_arb2`: a combinational 2-way grant with the pointer input, instantiated only under `AES_ICIPHER_RR_EN`.
- The registered state uses the r/rin/v two-process split used elsewhere in the codebase.

## Test plan
- Reset then single request: key 000102..0f, `req_data[0]`=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect `eng_enable` at A+1 and `rsp_valid[0]` at A+13.
  - Expect `rsp_data`=00112233445566778899aabbccddeeff.
- Backpressure: hold `rsp_ready[0]`=0 for 20 cycles.
  - `rsp_valid[0]` and `rsp_data` stay stable, and `req_ready` stays 0 throughout.
  - On release, IDLE is reached the next cycle.
- Simultaneous `req_valid`=11, `rsp_ready` always 1, four blocks each.
  - Without the macro: all four of requester 0 are served first.
  - With `AES_ICIPHER_RR_EN`: owners alternate 0,1,0,1,...
- Engine stub that never asserts `eng_ready`.
  - `err_timeout` pulses exactly TMO cycles after LAUNCH, the FSM returns to IDLE, and no `rsp_valid` is produced.
- Drive `rst` low during BUSY, round 5.
  - Outputs return to their reset values immediately, with no clock needed.
  - After release, a new block completes correctly with 13-cycle latency.
- Spurious `eng_ready` pulse in IDLE, and `rsp_ready[1]` while requester 0 owns HOLD.
  - Neither changes state or outputs.

Source files
------------

// File: rtl/aes_icipher_ctrl_pkg.sv
// Shared constants and controller register types for the inverse-cipher sequencer.
// Feature macro AES_ICIPHER_RR_EN (round-robin arbitration) is consumed by aes_icipher_ctrl.
package aes_const;
  localparam int NB     = 4;
  localparam int NR     = 10;
  localparam int NBYTES = 4 * NB;
endpackage

package aes_wire;
  import aes_const::*;

  localparam int TMO_DEF = NR + 4;
  localparam int WDOG_W  = $clog2(TMO_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    HOLD   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    ctrl_state_t       state;
    logic              owner;
    logic [WDOG_W-1:0] wdog;
    logic              rr_ptr;
  } ctrl_reg_type;

  localparam ctrl_reg_type CTRL_RESET = '{
    state:  IDLE,
    owner:  1'b0,
    wdog:   '0,
    rr_ptr: 1'b0
  };

  // Saturating watchdog step: the counter parks at all-ones instead of wrapping.
  function automatic logic [WDOG_W-1:0] wdog_step(input logic [WDOG_W-1:0] w);
    return (&w) ? w : w + 1'b1;
  endfunction
endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way combinational grant; i_ptr names the requester that wins a tie.
// Only instantiated when AES_ICIPHER_RR_EN is defined.
module aes_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = 2'b00;
    if (i_ptr) begin
      o_gnt[1] = i_req[1];
      o_gnt[0] = i_req[0] & ~i_req[1];
    end else begin
      o_gnt[0] = i_req[0];
      o_gnt[1] = i_req[1] & ~i_req[0];
    end
  end
endmodule

// File: rtl/aes_icipher_ctrl.sv
// Sequencer and 2-port arbiter in front of one aes_icipher_state engine.
// Define AES_ICIPHER_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module aes_icipher_ctrl
  import aes_const::*;
  import aes_wire::*;
#(
  parameter int NREQ = 2,
  parameter int TMO  = TMO_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ-1:0][0:NBYTES-1][7:0]   req_data,
  output logic [NREQ-1:0]                    req_ready,
  output logic [NREQ-1:0]                    rsp_valid,
  input  logic [NREQ-1:0]                    rsp_ready,
  output logic [0:NBYTES-1][7:0]             rsp_data,
  output logic [0:NBYTES-1][7:0]             eng_data,
  output logic                               eng_enable,
  input  logic [0:NBYTES-1][7:0]             eng_data_out,
  input  logic                               eng_ready,
  output logic                               err_timeout,
  output logic [1:0]                         dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
  // req_ready never depends on anything but req_valid and registered state.
  ctrl_reg_type            r_ctrl;
  ctrl_reg_type            w_rin;
  logic [0:NBYTES-1][7:0]  r_in_buf;
  logic [0:NBYTES-1][7:0]  r_out_buf;
  logic [NREQ-1:0]         w_gnt;
  logic [NREQ-1:0]         w_req_ready;
  logic                    w_load_in;
  logic                    w_load_out;
  logic                    w_timeout;

`ifdef AES_ICIPHER_RR_EN
  aes_rr_arb2 u_arb (
    .i_req (req_valid),
    .i_ptr (r_ctrl.rr_ptr),
    .o_gnt (w_gnt)
  );
`else
  assign w_gnt = {req_valid[1] & ~req_valid[0], req_valid[0]};
`endif

  always_comb begin
    w_rin       = r_ctrl;
    w_req_ready = '0;
    w_load_in   = 1'b0;
    w_load_out  = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_ctrl.state)
      IDLE: begin
        w_req_ready = w_gnt;
        if (|w_gnt) begin
          w_load_in   = 1'b1;
          w_rin.owner = w_gnt[1];
          w_rin.state = LAUNCH;
`ifdef AES_ICIPHER_RR_EN
          w_rin.rr_ptr = ~w_gnt[1];
`endif
        end
      end
      LAUNCH: begin
        w_rin.wdog  = '0;
        w_rin.state = BUSY;
      end
      BUSY: begin
        w_rin.wdog = wdog_step(r_ctrl.wdog);
        if (eng_ready) begin
          w_load_out  = 1'b1;
          w_rin.state = HOLD;
        end else if (r_ctrl.wdog == WDOG_W'(TMO - 1)) begin
          // Engine never answered: drop the block, the requester must resubmit.
          w_timeout   = 1'b1;
          w_rin.state = IDLE;
        end
      end
      HOLD: begin
        if (rsp_ready[r_ctrl.owner]) w_rin.state = IDLE;
      end
      default: w_rin = CTRL_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ctrl <= CTRL_RESET;
    else      r_ctrl <= w_rin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_buf  <= '0;
      r_out_buf <= '0;
    end else begin
      if (w_load_in)  r_in_buf  <= req_data[w_gnt[1]];
      if (w_load_out) r_out_buf <= eng_data_out;
    end
  end

  assign req_ready   = w_req_ready;
  assign eng_enable  = (r_ctrl.state == LAUNCH);
  assign eng_data    = r_in_buf;
  assign rsp_valid   = (r_ctrl.state == HOLD) ? {r_ctrl.owner, ~r_ctrl.owner} : 2'b00;
  assign rsp_data    = r_out_buf;
  assign err_timeout = w_timeout;
  assign dbg_state   = r_ctrl.state;

endmodule

// File: tb/tb_aes_icipher_ctrl.sv
// Directed-plus-random bench for aes_icipher_ctrl with a behavioural engine stub.
module tb_aes_icipher_ctrl;

  localparam int NR_T  = 10;
  localparam int LAT_T = NR_T + 3;
  localparam int TMO_T = NR_T + 4;
  localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_ICIPHER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             req_valid = '0;
  logic [1:0][0:15][7:0]  req_data  = '0;
  logic [1:0]             req_ready;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready = '0;
  logic [0:15][7:0]       rsp_data;
  logic [0:15][7:0]       eng_data;
  logic                   eng_enable;
  logic [0:15][7:0]       eng_dout   = '0;
  logic                   stub_ready = 1'b0;
  logic                   spur_ready = 1'b0;
  logic                   eng_dead   = 1'b0;
  logic                   eng_ready;
  logic                   err_timeout;
  logic [1:0]             dbg_state;
  int                     eng_cnt = 0;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  logic [127:0] exp_q[$];
  int           own_q[$];

  assign eng_ready = stub_ready | spur_ready;

  aes_icipher_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .eng_data     (eng_data),
    .eng_enable   (eng_enable),
    .eng_data_out (eng_dout),
    .eng_ready    (eng_ready),
    .err_timeout  (err_timeout),
    .dbg_state    (dbg_state)
  );

  // Engine reference: known-answer vector for the test key, otherwise a reversible scramble.
  function automatic logic [127:0] eng_model(input logic [127:0] c);
    if (c == KAT_CT) return KAT_PT;
    return {c[63:0], c[127:64]} ^ 128'h5a5a_c3c3_0f0f_a5a5_1234_5678_9abc_def0;
  endfunction

  // Engine stub: done pulse Nr+1 cycles after the enable cycle; shares the system reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_cnt    <= 0;
      stub_ready <= 1'b0;
      eng_dout   <= '0;
    end else begin
      stub_ready <= 1'b0;
      if (eng_enable && !eng_dead) begin
        eng_cnt  <= NR_T;
        eng_dout <= eng_model(eng_data);
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) stub_ready <= 1'b1;
      end
    end
  end

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [1:0] oh(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  // Arbitration rule: a lone requester wins; on a tie fixed priority picks 0,
  // round-robin picks the pointer and then moves it past the winner.
  function automatic int model_pick(input logic [1:0] v);
    int w;
    if (v == 2'b11) w = RR_MODE ? m_ptr : 0;
    else            w = v[1] ? 1 : 0;
    if (RR_MODE) m_ptr = 1 - w;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Driver: inputs for requester w are already on the bus; runs accept -> launch -> response.
  task automatic do_txn(input string tag, input int w, input logic [1:0] va,
                        input logic [127:0] da0, input logic [127:0] da1);
    int lat;
    logic [127:0] d;
    #1;
    chk({tag, ".gnt"}, 128'(req_ready), 128'(oh(w)));
    d = req_data[w];
    exp_q.push_back(eng_model(d));
    own_q.push_back(w);
    step();
    req_valid   = va;
    req_data[0] = da0;
    req_data[1] = da1;
    #1;
    chk({tag, ".en"}, 128'(eng_enable), 128'(1));
    chk({tag, ".edata"}, eng_data, d);
    step();
    chk({tag, ".en_pulse"}, 128'(eng_enable), 128'(0));
    lat = 2;
    while (rsp_valid == 2'b00 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, 128'(lat), 128'(LAT_T));
    chk({tag, ".rvalid"}, 128'(rsp_valid), 128'(oh(own_q.pop_front())));
    chk({tag, ".rdata"}, rsp_data, exp_q.pop_front());
  endtask

  initial begin
    int w, k, i0, i1;
    logic saw;
    logic [1:0] va;
    logic [127:0] da0, da1;
    logic [127:0] d0[4];
    logic [127:0] d1[4];

    // reset state
    step();
    step();
    chk("rst.req_ready", 128'(req_ready), 128'(0));
    chk("rst.rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst.eng_enable", 128'(eng_enable), 128'(0));
    chk("rst.err_timeout", 128'(err_timeout), 128'(0));
    chk("rst.rsp_data", rsp_data, 128'(0));
    chk("rst.eng_data", eng_data, 128'(0));
    chk("rst.state", 128'(dbg_state), 128'(aes_wire::IDLE));
    rst = 1'b1;
    step();

    // known-answer block on requester 0, response held back
    req_valid   = 2'b01;
    req_data[0] = KAT_CT;
    w = model_pick(req_valid);
    do_txn("kat", w, 2'b00, '0, '0);
    for (int i = 0; i < 20; i++) begin
      step();
      rsp_ready   = (i >= 5 && i < 10) ? 2'b10 : 2'b00;
      req_valid   = 2'b11;
      req_data[0] = rnd();
      req_data[1] = rnd();
      #1;
      chk("bp.rvalid", 128'(rsp_valid), 128'(2'b01));
      chk("bp.rdata", rsp_data, KAT_PT);
      chk("bp.req_ready", 128'(req_ready), 128'(0));
    end
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    #1;
    chk("bp.release_valid", 128'(rsp_valid), 128'(2'b01));
    step();
    rsp_ready = 2'b00;
    chk("bp.idle", 128'(dbg_state), 128'(aes_wire::IDLE));
    chk("bp.idle_rvalid", 128'(rsp_valid), 128'(0));

    // spurious done pulse while idle
    spur_ready = 1'b1;
    step();
    spur_ready = 1'b0;
    chk("spur.state", 128'(dbg_state), 128'(aes_wire::IDLE));
    chk("spur.rvalid", 128'(rsp_valid), 128'(0));
    chk("spur.en", 128'(eng_enable), 128'(0));
    chk("spur.rdata", rsp_data, KAT_PT);

    // both requesters continuously valid, four blocks each
    for (int j = 0; j < 4; j++) begin
      d0[j] = rnd();
      d1[j] = rnd();
    end
    i0 = 0;
    i1 = 0;
    rsp_ready   = 2'b11;
    req_valid   = 2'b11;
    req_data[0] = d0[0];
    req_data[1] = d1[0];
    for (int t = 0; t < 8; t++) begin
      w = model_pick(req_valid);
      if (w == 0) i0++;
      else        i1++;
      va  = {i1 < 4, i0 < 4};
      da0 = '0;
      da1 = '0;
      if (i0 < 4) da0 = d0[i0];
      if (i1 < 4) da1 = d1[i1];
      do_txn($sformatf("arb%0d", t), w, va, da0, da1);
      step();
    end

    // engine that never answers
    eng_dead    = 1'b1;
    req_valid   = 2'b10;
    req_data[0] = '0;
    req_data[1] = rnd();
    w = model_pick(req_valid);
    #1;
    chk("tmo.gnt", 128'(req_ready), 128'(oh(w)));
    step();
    req_valid = 2'b00;
    #1;
    chk("tmo.en", 128'(eng_enable), 128'(1));
    k   = 0;
    saw = 1'b0;
    while (err_timeout == 1'b0 && k < 40) begin
      step();
      k++;
      if (rsp_valid != 2'b00) saw = 1'b1;
    end
    chk("tmo.cycles", 128'(k), 128'(TMO_T));
    chk("tmo.no_rsp", 128'(saw), 128'(0));
    step();
    chk("tmo.idle", 128'(dbg_state), 128'(aes_wire::IDLE));
    chk("tmo.pulse", 128'(err_timeout), 128'(0));
    chk("tmo.rvalid", 128'(rsp_valid), 128'(0));
    eng_dead = 1'b0;

    // reset in the middle of an engine run
    req_valid   = 2'b01;
    req_data[0] = rnd();
    w = model_pick(req_valid);
    #1;
    chk("mrst.gnt", 128'(req_ready), 128'(oh(w)));
    step();
    req_valid = 2'b00;
    repeat (6) step();
    rst = 1'b0;
    #1;
    m_ptr = 0;
    chk("mrst.state", 128'(dbg_state), 128'(aes_wire::IDLE));
    chk("mrst.en", 128'(eng_enable), 128'(0));
    chk("mrst.rvalid", 128'(rsp_valid), 128'(0));
    chk("mrst.req_ready", 128'(req_ready), 128'(0));
    chk("mrst.err", 128'(err_timeout), 128'(0));
    chk("mrst.edata", eng_data, 128'(0));
    chk("mrst.rdata", rsp_data, 128'(0));
    step();
    step();
    rst = 1'b1;
    step();
    req_valid   = 2'b10;
    req_data[1] = rnd();
    w = model_pick(req_valid);
    do_txn("post_rst", w, 2'b00, '0, '0);
    step();
    chk("post_rst.idle", 128'(dbg_state), 128'(aes_wire::IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
